mux4_rr_sched: RTL and testbench
================================

# mux4_rr_sched

Round-robin scheduler that shares the 4:1 mux datapath between four requesters. It owns the mux select lines (a0/b0 pair, here `sel[1:0]`) and grants exactly one data line at a time. It drives a registered mux output `f` and enforces a one-cycle turnaround between owners. It sits between the four requesting sources and the combinational 4:1 mux.

## Interface
- `MAX_HOLD`, 4: maximum consecutive GRANT cycles per owner when the hold limit is compiled in; legal range 1..15.
- `CW`, 4: width of the hold counter; must satisfy 2^CW > MAX_HOLD.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per source; `req[i]` asks for mux line i.
- `data`  in  4  mux data lines; bit 0..3 correspond to inputs a, b, c, d.
- `sel`  out  2  mux select; `sel[1]` is a0, `sel[0]` is b0; value i selects `data[i]`.
- `gnt`  out  4  one-hot grant; all-zero when no owner.
- `busy`  out  1  high in GRANT and SWITCH.
- `f`  out  1  registered mux output.

## Operation
- Reset values: state IDLE, `gnt`=4'b0000, `sel`=2'b00, `busy`=0, `f`=0, hold counter=0, last-owner pointer=3 (so source 0 wins first).
- States:
  - IDLE: `gnt`=0, `busy`=0.
  - GRANT: exactly one `gnt` bit set, `sel` = owner index, `busy`=1.
  - SWITCH: `gnt`=0, `sel` holds the previous owner, `busy`=1.
- Winner selection searches from pointer+1 upward, mod 4: `(ptr+1)`, `(ptr+2)`, `(ptr+3)`, `ptr`. The first asserted `req` bit wins. The pointer is updated to the winner on entry to GRANT.
- IDLE → GRANT when `req`≠0; otherwise stay in IDLE.
- GRANT → SWITCH when `req[owner]`=0 at the edge, or when the hold limit is reached (see Configuration). Otherwise stay in GRANT.
- SWITCH → GRANT with a new winner if `req`≠0; otherwise SWITCH → IDLE.
- Hold counter:
  - Loads 1 on entry to GRANT.
  - Increments each GRANT cycle and saturates at MAX_HOLD.
  - Cleared in IDLE and SWITCH.
- `f`: registered every edge. `f` <= `data[sel]` if `gnt`≠0 in the current cycle, else 0.
- Request bits for non-owners have no effect during GRANT.
- A simultaneous owner release and new requests still passes through SWITCH for one cycle.

## Timing
- Grant latency: `req` asserted before edge N while in IDLE → `gnt`/`sel` valid after edge N (1 cycle).
- Owner handover: minimum 1 SWITCH cycle with `gnt`=0 between any two grants, including a re-grant to the same source.
- `f` lags `sel`/`data` by 1 cycle.
  - The first valid `f` appears the cycle after the first GRANT cycle.
  - `f` returns to 0 one cycle after `gnt` clears.
- Release: owner drops `req` before edge N → SWITCH after edge N.
- Reset mid-operation: `rst_n` low forces all outputs to their reset values immediately, without waiting for a clock edge.
  - The pointer returns to 3.
  - The first grant after release follows normal 1-cycle latency.

## Configuration
- `MUX_SCHED_HOLD_LIMIT_EN` defined:
  - GRANT → SWITCH also occurs when the hold counter equals MAX_HOLD at the edge, even if `req[owner]` is still high.
  - The owner therefore holds the mux for at most MAX_HOLD cycles.
  - A sole requester is re-granted after the 1-cycle SWITCH.
- Not defined:
  - The hold counter is not implemented.
  - The owner keeps the grant for as long as `req[owner]` stays high; other requesters can starve.

## Test plan
- Reset then `req`=4'b0001, `data`=4'b0001:
  - `gnt`=0001 and `sel`=00 after 1 edge.
  - `f`=1 after 2 edges.
  - `busy`=1.
- `req`=4'b1111 held, hold limit enabled, MAX_HOLD=4:
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 4 cycles, separated by 1 cycle with `gnt`=0.
- Owner 2 granted, then `req`=4'b1010 with `req[2]` dropped:
  - 1 SWITCH cycle, then owner 3 (search from 3 wraps 3,0,1).
  - `sel`=11.
- `req`=4'b0100 sole and continuous, limit enabled, MAX_HOLD=2:
  - Pattern is `gnt`=0100 for 2 cycles, 0000 for 1 cycle, repeating.
  - With the macro undefined, `gnt` stays at 0100 continuously.
- `rst_n` pulsed low mid-GRANT (owner 1, `f`=1):
  - Outputs go 0 asynchronously.
  - With `req`=4'b0011 after release, source 0 wins first.
- `req` drops to 0 during GRANT:
  - SWITCH for 1 cycle, then IDLE with `busy`=0.
  - `f`=0 one cycle after `gnt` clears.

Source files
------------

// File: rtl/mux4_rr_sched.sv
// Round-robin owner of the 4:1 mux select; registered output f, one SWITCH cycle between owners.
// Latency: gnt/sel 1 cycle after req, f 1 cycle after sel. Optional hold limit: MUX_SCHED_HOLD_LIMIT_EN.
// Backpressure: none; an owner holds the mux while its req stays high (or until the hold limit).
module mux4_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       f
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    if ((MAX_HOLD < 1) || (MAX_HOLD > 15) || ((2 ** CW) <= MAX_HOLD)) begin : g_bad_cfg
        $error("mux4_rr_sched: MAX_HOLD must be 1..15 and fit in CW bits");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_vld;
    logic       grant_load;
    logic [1:0] sel_nxt;
    logic       hold_done;

    // Search order starts just past the last owner, so the last owner is tried last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + k[1:0];
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef MUX_SCHED_HOLD_LIMIT_EN
    logic [CW-1:0] hold_cnt;

    assign hold_done = (hold_cnt == CW'(MAX_HOLD));

    // Counter value equals the index of the current GRANT cycle (1-based), saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state_nxt == GRANT) begin
            if (state != GRANT)
                hold_cnt <= CW'(1);
            else if (!hold_done)
                hold_cnt <= hold_cnt + CW'(1);
        end else begin
            hold_cnt <= '0;
        end
    end
`else
    assign hold_done = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_vld)
                    state_nxt = GRANT;
            end
            GRANT: begin
                if (!req[sel] || hold_done)
                    state_nxt = SWITCH;
            end
            SWITCH: begin
                state_nxt = win_vld ? GRANT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_load = (state != GRANT) && (state_nxt == GRANT);
    assign sel_nxt    = grant_load ? win_idx : sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd3;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            f     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_load)
                ptr <= win_idx;
            sel  <= sel_nxt;
            gnt  <= (state_nxt == GRANT) ? (4'b0001 << sel_nxt) : 4'b0000;
            busy <= (state_nxt != IDLE);
            // f samples the line selected during the current cycle, hence one cycle behind sel.
            f    <= (|gnt) ? data[sel] : 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: directed scenarios plus randomized req/data against a behavioural model.
module tb_mux4_rr_sched;

    localparam int MAX_HOLD = 4;
`ifdef MUX_SCHED_HOLD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] data  = 4'b0000;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       f;

    always #5 clk = ~clk;

    mux4_rr_sched #(.MAX_HOLD(MAX_HOLD), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .data  (data),
        .sel   (sel),
        .gnt   (gnt),
        .busy  (busy),
        .f     (f)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       f;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: phase 0 = nobody owns, 1 = someone owns, 2 = mandatory gap cycle.
    int         m_phase;
    int         m_owner;
    int         m_last;
    int         m_run;
    logic [1:0] m_sel;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_last  = 3;
        m_run   = 0;
        m_sel   = 2'd0;
    endtask

    // Advance the model across one rising edge with inputs r/d, queue the resulting outputs.
    task automatic model_step(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        int   w;
        logic nf;
        nf = (m_phase == 1) ? d[m_owner] : 1'b0;
        if (m_phase == 1) begin
            if (!r[m_owner] || (LIMIT && m_run == MAX_HOLD)) begin
                m_phase = 2;
                m_run   = 0;
            end else if (m_run < MAX_HOLD) begin
                m_run++;
            end
        end else begin
            w = pick(r);
            if (w >= 0) begin
                m_phase = 1;
                m_owner = w;
                m_last  = w;
                m_sel   = 2'(w);
                m_run   = 1;
            end else begin
                m_phase = 0;
            end
        end
        e.gnt  = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel  = m_sel;
        e.busy = (m_phase != 0);
        e.f    = nf;
        q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        req  = r;
        data = d;
        model_step(r, d);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},  {4'b0, gnt},   8'h00);
        chk({tag, "_sel"},  {6'b0, sel},   8'h00);
        chk({tag, "_busy"}, {7'b0, busy},  8'h00);
        chk({tag, "_f"},    {7'b0, f},     8'h00);
    endtask

    // Assert reset mid-cycle, check outputs clear without an edge, then release together with new inputs.
    task automatic do_reset(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        data  = d;
        model_step(r, d);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt",  {4'b0, gnt},  {4'b0, e.gnt});
                chk("sel",  {6'b0, sel},  {6'b0, e.sel});
                chk("busy", {7'b0, busy}, {7'b0, e.busy});
                chk("f",    {7'b0, f},    {7'b0, e.f});
            end
        end
    end

    initial begin : driver
        logic [3:0] r_cur;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        model_reset();

        // First grant from reset, f follows one cycle later.
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0001;
        data  = 4'b0001;
        model_step(4'b0001, 4'b0001);
        repeat (5) drive(4'b0001, 4'b0001);

        // All requesting: rotation (and hold limit when compiled in).
        repeat (30) drive(4'b1111, 4'($urandom));

        // Sole continuous requester.
        repeat (12) drive(4'b0100, 4'($urandom));

        // Owner 2 releases while 1 and 3 request: 3 wins after the gap.
        repeat (3) drive(4'b0000, 4'b0000);
        repeat (2) drive(4'b0100, 4'($urandom));
        repeat (5) drive(4'b1010, 4'b1000);

        // Requests vanish during a grant.
        repeat (3) drive(4'b1000, 4'b1000);
        repeat (4) drive(4'b0000, 4'($urandom));

        // Reset while owner 1 holds with f=1; afterwards source 0 wins first.
        repeat (3) drive(4'b0000, 4'b0000);
        repeat (3) drive(4'b0010, 4'b0010);
        do_reset(4'b0011, 4'b0011);
        repeat (4) drive(4'b0011, 4'b0011);

        // Randomized traffic with sticky requests and occasional reset.
        r_cur = 4'($urandom);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                r_cur = 4'($urandom);
            if (m_phase == 1 && $urandom_range(0, 40) == 0)
                do_reset(r_cur, 4'($urandom));
            else
                drive(r_cur, 4'($urandom));
        end

        repeat (3) drive(4'b0000, 4'b0000);
        @(posedge clk);
        #2;
        chk("drain", 8'(q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
